// File: rtl/fp_arbiter_cell.sv
`default_nettype none
// ============================================================================
// Module   : fp_arbiter_cell
// Purpose  : One bit-slice of a ripple fixed-priority arbiter. The priority
//            carry enters on Cin from the next higher-priority cell and
//            leaves on Cout toward the next lower-priority cell. The first
//            requesting cell that sees the carry takes the grant and kills
//            the carry below it. A registered grant copy and a saturating
//            grant-cycle counter feed the statistics path.
// Ports    : Cout       - out, carry to next lower-priority cell
//            Grant      - out, combinational grant (r & Cin)
//            r          - in,  request from this cell's requester
//            Cin        - in,  carry from next higher-priority cell
//            clk        - in,  system clock (registered outputs only)
//            reset      - in,  asynchronous active-high reset
//            GrantQ     - out, Grant registered on rising clk
//            GrantCount - out, saturating count of edges with Grant = 1
// Revision : 1.0 - initial release
// ============================================================================
module fp_arbiter_cell #(
  parameter int COUNT_W = 16
) (
  output logic               Cout,
  output logic               Grant,
  input  logic               r,
  input  logic               Cin,
  input  logic               clk,
  input  logic               reset,
  output logic               GrantQ,
  output logic [COUNT_W-1:0] GrantCount
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic               grant_q;
  logic               grant_d;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Pure carry logic: no masking, so an X on r or Cin reaches the outputs.
  assign Grant = r & Cin;
  assign Cout  = ~r & Cin;

  always_comb begin
    grant_d = Grant;
    count_d = count_q;
    // Counter holds once saturated instead of wrapping to zero.
    if (Grant && (count_q != COUNT_MAX)) begin
      count_d = count_q + COUNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant_q <= 1'b0;
      count_q <= '0;
    end else begin
      grant_q <= grant_d;
      count_q <= count_d;
    end
  end

  assign GrantQ     = grant_q;
  assign GrantCount = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_arbiter_cell.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_fp_arbiter_cell
// Purpose  : Self-checking bench for fp_arbiter_cell: truth table, async
//            reset, counter gating, saturation (3-bit counter), a 4-cell
//            chain and a random invariant run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_arbiter_cell;

  logic clk = 1'b0;
  logic reset;
  logic r, cin;
  logic cout, grant, grant_q;
  logic [15:0] grant_count;

  logic r3, cin3;
  logic cout3, grant3, grant_q3;
  logic [2:0] grant_count3;

  logic [3:0] req;
  logic [4:0] carry;
  logic [3:0] ch_grant;
  logic [3:0] ch_q;
  logic [15:0] ch_cnt [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_arbiter_cell #(.COUNT_W(16)) dut (
    .Cout(cout), .Grant(grant), .r(r), .Cin(cin), .clk(clk), .reset(reset),
    .GrantQ(grant_q), .GrantCount(grant_count)
  );

  fp_arbiter_cell #(.COUNT_W(3)) dut3 (
    .Cout(cout3), .Grant(grant3), .r(r3), .Cin(cin3), .clk(clk), .reset(reset),
    .GrantQ(grant_q3), .GrantCount(grant_count3)
  );

  assign carry[0] = 1'b1;
  for (genvar i = 0; i < 4; i++) begin : g_chain
    fp_arbiter_cell #(.COUNT_W(16)) u_cell (
      .Cout(carry[i+1]), .Grant(ch_grant[i]), .r(req[i]), .Cin(carry[i]),
      .clk(clk), .reset(reset), .GrantQ(ch_q[i]), .GrantCount(ch_cnt[i])
    );
  end

  typedef struct {
    logic r;
    logic cin;
    logic exp_grant;
    logic exp_cout;
  } vec_t;

  typedef struct {
    logic [3:0] req;
    logic [3:0] exp_grant;
    logic       exp_tail;
  } chain_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    vec_t       tv [5];
    chain_vec_t cv [3];
    logic       pat [4];
    logic       exp_q;
    logic [15:0] exp_cnt;

    tv[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tv[3] = '{1'b1, 1'b0, 1'b0, 1'b0};
    tv[4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Bit i is cell i; cell 0 has highest priority.
    cv[0] = '{4'b0110, 4'b0010, 1'b0};
    cv[1] = '{4'b0000, 4'b0000, 1'b1};
    cv[2] = '{4'b1111, 4'b0001, 1'b0};

    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b0;

    reset = 1'b1;
    r = 1'b0; cin = 1'b0; r3 = 1'b0; cin3 = 1'b0; req = 4'b0000;

    // Truth table, each vector held 100 ps.
    for (int i = 0; i < 5; i++) begin
      r   = tv[i].r;
      cin = tv[i].cin;
      #0.05;
      check($sformatf("tt%0d_grant", i), {31'b0, grant}, {31'b0, tv[i].exp_grant});
      check($sformatf("tt%0d_cout", i),  {31'b0, cout},  {31'b0, tv[i].exp_cout});
      #0.05;
    end

    // Reset state; Grant still follows inputs during reset.
    #1;
    check("rst_grantq", {31'b0, grant_q}, 32'd0);
    check("rst_count",  {16'b0, grant_count}, 32'd0);
    check("rst_grant_live", {31'b0, grant}, 32'd1);

    // Five granted cycles.
    @(negedge clk);
    reset = 1'b0; r = 1'b1; cin = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("cnt5_count",  {16'b0, grant_count}, 32'd5);
    check("cnt5_grantq", {31'b0, grant_q}, 32'd1);

    // Mid-cycle async reset pulse.
    #2;
    reset = 1'b1;
    #1;
    check("async_grantq", {31'b0, grant_q}, 32'd0);
    check("async_count",  {16'b0, grant_count}, 32'd0);
    check("async_grant",  {31'b0, grant}, 32'd1);
    reset = 1'b0;

    // Counter gating with r toggling 1,0,1,0.
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      r = pat[k];
      @(posedge clk);
      #1;
      check($sformatf("gate%0d_grantq", k), {31'b0, grant_q}, {31'b0, pat[k]});
      @(negedge clk);
    end
    check("gate_count", {16'b0, grant_count}, 32'd2);

    // Saturation with a 3-bit counter.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    r3 = 1'b1; cin3 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat%0d_count", i), {29'b0, grant_count3},
            (i + 1 > 7) ? 32'd7 : 32'(i + 1));
    end
    r3 = 1'b0;

    // 4-cell chain.
    for (int i = 0; i < 3; i++) begin
      req = cv[i].req;
      #1;
      check($sformatf("chain%0d_grant", i), {28'b0, ch_grant}, {28'b0, cv[i].exp_grant});
      check($sformatf("chain%0d_tail", i),  {31'b0, carry[4]}, {31'b0, cv[i].exp_tail});
    end

    // Random run: inputs change on negedge, checked on the following negedge.
    @(negedge clk);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_cnt = grant_count;
    for (int i = 0; i < 1000; i++) begin
      r     = 1'($urandom_range(0, 1));
      cin   = 1'($urandom_range(0, 1));
      reset = ($urandom_range(0, 15) == 0);
      @(posedge clk);
      exp_q = reset ? 1'b0 : (r & cin);
      if (reset) exp_cnt = 16'd0;
      else if ((r & cin) && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      @(negedge clk);
      check("rnd_exclusive", {31'b0, grant & cout}, 32'd0);
      check("rnd_grantq", {31'b0, grant_q}, {31'b0, exp_q});
      check("rnd_count", {16'b0, grant_count}, {16'b0, exp_cnt});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
